// File: rtl/frame_buf_sched_if.sv
// Frame scheduler <-> SDRAM address controller bus.
// The master is the scheduler. The slave is the controller and frame-timing side.
interface frame_buf_sched_if;
  logic        sdram_init_done;
  logic        wr_vs;
  logic        rd_vs;
  logic        frame_write_done;
  logic        wr_load;
  logic [21:0] wr_addr;
  logic [21:0] wr_max_addr;
  logic        rd_load;
  logic [21:0] rd_addr;
  logic [21:0] rd_max_addr;
  logic        wr_bank;
  logic        rd_bank;
  logic        rd_frame_valid;
  logic [15:0] drop_cnt;

  modport master (
    input  sdram_init_done, wr_vs, rd_vs, frame_write_done,
    output wr_load, wr_addr, wr_max_addr, rd_load, rd_addr, rd_max_addr,
           wr_bank, rd_bank, rd_frame_valid, drop_cnt
  );

  modport slave (
    output sdram_init_done, wr_vs, rd_vs, frame_write_done,
    input  wr_load, wr_addr, wr_max_addr, rd_load, rd_addr, rd_max_addr,
           wr_bank, rd_bank, rd_frame_valid, drop_cnt
  );
endinterface

// File: rtl/frame_buf_sched.sv
// Ping-pong frame buffer scheduler.
// Assigns SDRAM banks to the writer and the reader, and issues address load
// pulses. The writer never targets the bank on display. A new input frame is
// dropped while a completed frame is still waiting for the display.
module frame_buf_sched #(
  parameter logic [21:0] BANK0_BASE  = 22'h000000,
  parameter logic [21:0] BANK1_BASE  = 22'h200000,
  parameter logic [21:0] FRAME_SIZE  = 22'd130560,
  parameter int          LOAD_CYCLES = 4
) (
  input  logic               clk_ref,
  input  logic               rst,
  frame_buf_sched_if.master  bus
);

  localparam int CNT_W = $clog2(LOAD_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_FULL = CNT_W'(LOAD_CYCLES);

  typedef enum logic [2:0] {W_IDLE, W_LOAD, W_WRITE, W_DONE, W_HOLD} wstate_t;

  wstate_t          state, state_nxt;
  logic [CNT_W-1:0] wr_cnt, rd_cnt;
  logic             fwd_d1, fwd_rise;
  logic             ready_valid, ready_bank;
  logic             wr_bank, rd_bank, rd_frame_valid;
  logic [21:0]      wr_addr, wr_max_addr, rd_addr, rd_max_addr;
  logic [15:0]      drop_cnt;
  logic             wr_start, wr_drop, rd_busy, rd_take, rd_go;

  function automatic logic [21:0] bank_base(input logic b);
    return b ? BANK1_BASE : BANK0_BASE;
  endfunction

  assign fwd_rise = bus.frame_write_done & ~fwd_d1;
  assign wr_start = (state_nxt == W_LOAD) && (state != W_LOAD);
  assign wr_drop  = bus.wr_vs && ((state == W_WRITE) || ((state == W_HOLD) && ready_valid));
  assign rd_busy  = (rd_cnt != '0);
  assign rd_take  = bus.rd_vs && !rd_busy && ready_valid;
  assign rd_go    = bus.rd_vs && !rd_busy && (ready_valid || rd_frame_valid);

  // Delayed copy of frame_write_done, kept every cycle so a held level never reads as a rise
  always_ff @(posedge clk_ref) begin
    fwd_d1 <= bus.frame_write_done;
  end

  // Write FSM state register and load-pulse counter
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      state  <= W_IDLE;
      wr_cnt <= '0;
    end else begin
      state  <= state_nxt;
      wr_cnt <= (state == W_LOAD && state_nxt == W_LOAD) ? wr_cnt + CNT_W'(1) : '0;
    end
  end

  // Write FSM next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      W_IDLE:  if (bus.sdram_init_done && bus.wr_vs) state_nxt = W_LOAD;
      W_LOAD:  if (wr_cnt == LOAD_LAST)              state_nxt = W_WRITE;
      W_WRITE: if (fwd_rise)                         state_nxt = W_DONE;
      W_DONE:                                        state_nxt = W_HOLD;
      W_HOLD:  if (bus.wr_vs && !ready_valid)        state_nxt = W_LOAD;
      default:                                       state_nxt = W_IDLE;
    endcase
  end

  // Load pulse outputs decoded from the FSM state and the read counter
  always_comb begin
    bus.wr_load = (state == W_LOAD);
    bus.rd_load = rd_busy;
  end

  // Writer bank and addresses latched on entry to W_LOAD, opposite the displayed bank
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      wr_bank     <= 1'b0;
      wr_addr     <= BANK0_BASE;
      wr_max_addr <= BANK0_BASE + FRAME_SIZE;
    end else if (wr_start) begin
      wr_bank     <= ~rd_bank;
      wr_addr     <= bank_base(~rd_bank);
      wr_max_addr <= bank_base(~rd_bank) + FRAME_SIZE;
    end
  end

  // Hand-off slot for a completed frame; set in W_DONE and emptied when the reader takes it
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      ready_valid <= 1'b0;
      ready_bank  <= 1'b0;
    end else if (state == W_DONE) begin
      ready_valid <= 1'b1;
      ready_bank  <= wr_bank;
    end else if (rd_take) begin
      ready_valid <= 1'b0;
    end
  end

  // Reader bank swap on rd_vs and load-pulse countdown
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      rd_bank        <= 1'b1;
      rd_addr        <= BANK1_BASE;
      rd_max_addr    <= BANK1_BASE + FRAME_SIZE;
      rd_frame_valid <= 1'b0;
      rd_cnt         <= '0;
    end else begin
      if (rd_take) begin
        rd_bank        <= ready_bank;
        rd_addr        <= bank_base(ready_bank);
        rd_max_addr    <= bank_base(ready_bank) + FRAME_SIZE;
        rd_frame_valid <= 1'b1;
      end
      if (rd_go)
        rd_cnt <= LOAD_FULL;
      else if (rd_busy)
        rd_cnt <= rd_cnt - CNT_W'(1);
    end
  end

  // Saturating count of wr_vs pulses that could not start a frame
  always_ff @(posedge clk_ref) begin
    if (rst)
      drop_cnt <= '0;
    else if (wr_drop && drop_cnt != 16'hFFFF)
      drop_cnt <= drop_cnt + 16'd1;
  end

  assign bus.wr_bank        = wr_bank;
  assign bus.wr_addr        = wr_addr;
  assign bus.wr_max_addr    = wr_max_addr;
  assign bus.rd_bank        = rd_bank;
  assign bus.rd_addr        = rd_addr;
  assign bus.rd_max_addr    = rd_max_addr;
  assign bus.rd_frame_valid = rd_frame_valid;
  assign bus.drop_cnt       = drop_cnt;

endmodule

// File: tb/tb_frame_buf_sched.sv
// Directed bench for frame_buf_sched. Inputs change 1 time unit after the
// rising edge and outputs are sampled there too.
module tb_frame_buf_sched;

  localparam logic [21:0] B0     = 22'h000000;
  localparam logic [21:0] B1     = 22'h200000;
  localparam logic [21:0] B0_MAX = 22'h01FE00;
  localparam logic [21:0] B1_MAX = 22'h21FE00;

  logic clk_ref;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   n;

  frame_buf_sched_if bus ();

  frame_buf_sched dut (
    .clk_ref (clk_ref),
    .rst     (rst),
    .bus     (bus)
  );

  initial begin
    clk_ref = 1'b0;
    forever #5 clk_ref = ~clk_ref;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_ref);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic pulse_wr();
    bus.wr_vs = 1'b1;
    tick();
    bus.wr_vs = 1'b0;
  endtask

  task automatic pulse_rd();
    bus.rd_vs = 1'b1;
    tick();
    bus.rd_vs = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".wr_bank"},   32'(bus.wr_bank), 32'(1'b0));
    chk({tag, ".rd_bank"},   32'(bus.rd_bank), 32'(1'b1));
    chk({tag, ".wr_load"},   32'(bus.wr_load), 32'(1'b0));
    chk({tag, ".rd_load"},   32'(bus.rd_load), 32'(1'b0));
    chk({tag, ".wr_addr"},   32'(bus.wr_addr), 32'(B0));
    chk({tag, ".wr_max"},    32'(bus.wr_max_addr), 32'(B0_MAX));
    chk({tag, ".rd_addr"},   32'(bus.rd_addr), 32'(B1));
    chk({tag, ".rd_max"},    32'(bus.rd_max_addr), 32'(B1_MAX));
    chk({tag, ".rd_fvalid"}, 32'(bus.rd_frame_valid), 32'(1'b0));
    chk({tag, ".drop_cnt"},  32'(bus.drop_cnt), 32'd0);
  endtask

  initial begin
    rst                  = 1'b1;
    bus.sdram_init_done  = 1'b0;
    bus.wr_vs            = 1'b0;
    bus.rd_vs            = 1'b0;
    bus.frame_write_done = 1'b0;
    tick(); tick(); tick();
    chk_reset("reset");
    rst = 1'b0;
    tick();

    // wr_vs before SDRAM init is ignored and not counted
    pulse_wr();
    chk("preinit.wr_load", 32'(bus.wr_load), 32'(1'b0));
    tick();
    chk("preinit.drop", 32'(bus.drop_cnt), 32'd0);

    // First write frame into bank 0
    bus.sdram_init_done = 1'b1;
    tick();
    pulse_wr();
    chk("wr1.load",   32'(bus.wr_load), 32'(1'b1));
    chk("wr1.bank",   32'(bus.wr_bank), 32'(1'b0));
    chk("wr1.addr",   32'(bus.wr_addr), 32'(B0));
    chk("wr1.max",    32'(bus.wr_max_addr), 32'(B0_MAX));
    n = 0;
    while (bus.wr_load && n < 20) begin n++; tick(); end
    chk("wr1.len", 32'(n), 32'd4);

    // Display asks before any frame completed: nothing to load
    pulse_rd();
    chk("rd0.load",   32'(bus.rd_load), 32'(1'b0));
    chk("rd0.fvalid", 32'(bus.rd_frame_valid), 32'(1'b0));
    chk("rd0.bank",   32'(bus.rd_bank), 32'(1'b1));

    // Frame 1 completes; reader takes bank 0
    bus.frame_write_done = 1'b1;
    tick(); tick(); tick();
    pulse_rd();
    chk("rd1.load",   32'(bus.rd_load), 32'(1'b1));
    chk("rd1.bank",   32'(bus.rd_bank), 32'(1'b0));
    chk("rd1.addr",   32'(bus.rd_addr), 32'(B0));
    chk("rd1.max",    32'(bus.rd_max_addr), 32'(B0_MAX));
    chk("rd1.fvalid", 32'(bus.rd_frame_valid), 32'(1'b1));
    n = 0;
    while (bus.rd_load && n < 20) begin n++; tick(); end
    chk("rd1.len", 32'(n), 32'd4);

    // Second write frame goes to bank 1; frame_write_done still high from before
    pulse_wr();
    chk("wr2.load", 32'(bus.wr_load), 32'(1'b1));
    chk("wr2.bank", 32'(bus.wr_bank), 32'(1'b1));
    chk("wr2.addr", 32'(bus.wr_addr), 32'(B1));
    chk("wr2.max",  32'(bus.wr_max_addr), 32'(B1_MAX));
    n = 0;
    while (bus.wr_load && n < 20) begin n++; tick(); end
    chk("wr2.len", 32'(n), 32'd4);
    tick(); tick(); tick();

    // Repeat display: held level must not have completed a frame, rd_bank unchanged
    pulse_rd();
    chk("rd2.load", 32'(bus.rd_load), 32'(1'b1));
    chk("rd2.bank", 32'(bus.rd_bank), 32'(1'b0));
    chk("rd2.addr", 32'(bus.rd_addr), 32'(B0));
    n = 0;
    while (bus.rd_load && n < 20) begin
      bus.rd_vs = (n == 1);
      n++;
      tick();
    end
    bus.rd_vs = 1'b0;
    chk("rd2.len", 32'(n), 32'd4);

    // Frame 2 completes on a fresh rising edge; three input frames are dropped
    bus.frame_write_done = 1'b0;
    tick();
    bus.frame_write_done = 1'b1;
    tick(); tick(); tick();
    for (int i = 0; i < 3; i++) begin
      pulse_wr();
      chk("drop.wr_load", 32'(bus.wr_load), 32'(1'b0));
    end
    chk("drop.cnt3", 32'(bus.drop_cnt), 32'd3);

    // Reader swaps to bank 1, writer then goes to bank 0
    pulse_rd();
    chk("rd3.load", 32'(bus.rd_load), 32'(1'b1));
    chk("rd3.bank", 32'(bus.rd_bank), 32'(1'b1));
    chk("rd3.addr", 32'(bus.rd_addr), 32'(B1));
    chk("rd3.max",  32'(bus.rd_max_addr), 32'(B1_MAX));
    tick(); tick(); tick(); tick();
    pulse_wr();
    chk("wr3.load", 32'(bus.wr_load), 32'(1'b1));
    chk("wr3.bank", 32'(bus.wr_bank), 32'(1'b0));
    chk("wr3.addr", 32'(bus.wr_addr), 32'(B0));
    tick(); tick(); tick(); tick();
    chk("wr3.end", 32'(bus.wr_load), 32'(1'b0));

    // Overrun while writing counts a drop and starts nothing
    pulse_wr();
    chk("ovr.wr_load", 32'(bus.wr_load), 32'(1'b0));
    chk("ovr.cnt4",    32'(bus.drop_cnt), 32'd4);

    // Reset in the middle of a write frame
    rst = 1'b1;
    tick();
    chk_reset("midrst");
    rst = 1'b0;
    bus.frame_write_done = 1'b0;
    tick();
    bus.frame_write_done = 1'b1;
    tick(); tick(); tick();
    pulse_rd();
    chk("postrst.rd_load", 32'(bus.rd_load), 32'(1'b0));
    chk("postrst.fvalid",  32'(bus.rd_frame_valid), 32'(1'b0));
    pulse_wr();
    chk("postrst.wr_load", 32'(bus.wr_load), 32'(1'b1));
    chk("postrst.wr_bank", 32'(bus.wr_bank), 32'(1'b0));
    tick(); tick(); tick(); tick();

    // rd_vs in the W_DONE cycle sees no ready frame; the next rd_vs takes it
    bus.frame_write_done = 1'b0;
    tick();
    bus.frame_write_done = 1'b1;
    tick();
    pulse_rd();
    chk("coinc.rd_load", 32'(bus.rd_load), 32'(1'b0));
    chk("coinc.rd_bank", 32'(bus.rd_bank), 32'(1'b1));
    pulse_rd();
    chk("late.rd_load", 32'(bus.rd_load), 32'(1'b1));
    chk("late.rd_bank", 32'(bus.rd_bank), 32'(1'b0));
    chk("late.fvalid",  32'(bus.rd_frame_valid), 32'(1'b1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
